// File: rtl/gpio_led_module_if.sv
// LED bundle driven by gpio_led_module: four cumulative status LEDs plus completion LED.
interface gpio_led_module_if;
  logic led1;
  logic led2;
  logic led3;
  logic led4;
  logic led_done;

  modport master (output led1, led2, led3, led4, led_done);
  modport slave  (input  led1, led2, led3, led4, led_done);
endinterface

// File: rtl/gpio_led_module.sv
// Self-timed bring-up LED sequencer: lights led1..led4 one per prescaler tick, then led_done.
// Optional GPIO_DONE_BLINK_EN: led_done toggles on every tick once the sequence is complete.
module gpio_led_module #(
  parameter int unsigned TICK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  gpio_led_module_if.master led_if
);

  localparam int unsigned CW = $clog2(TICK_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S4   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  logic [CW-1:0] r_cnt;
  logic          w_tick;
  state_t        r_state;
  state_t        w_next;
  logic [3:0]    w_led_nxt;
  logic [3:0]    r_led;
  logic          r_done;

  // Prescaler runs in every state, including DONE.
  assign w_tick = (r_cnt == CW'(TICK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_led_nxt = 4'b0000;
    case (r_state)
      ST_IDLE: if (w_tick) w_next = ST_S1;
      ST_S1:   if (w_tick) w_next = ST_S2;
      ST_S2:   if (w_tick) w_next = ST_S3;
      ST_S3:   if (w_tick) w_next = ST_S4;
      ST_S4:   if (w_tick) w_next = ST_DONE;
      ST_DONE: w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
    // Thermometer decode of the state being entered, so the pins are registered copies.
    case (w_next)
      ST_S1:   w_led_nxt = 4'b0001;
      ST_S2:   w_led_nxt = 4'b0011;
      ST_S3:   w_led_nxt = 4'b0111;
      ST_S4:   w_led_nxt = 4'b1111;
      ST_DONE: w_led_nxt = 4'b1111;
      default: w_led_nxt = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led  <= 4'b0000;
      r_done <= 1'b0;
    end else begin
      r_led <= w_led_nxt;
`ifdef GPIO_DONE_BLINK_EN
      if (w_next != ST_DONE)      r_done <= 1'b0;
      else if (r_state != ST_DONE) r_done <= 1'b1;
      else if (w_tick)             r_done <= ~r_done;
`else
      r_done <= (w_next == ST_DONE);
`endif
    end
  end

  assign led_if.led1     = r_led[0];
  assign led_if.led2     = r_led[1];
  assign led_if.led3     = r_led[2];
  assign led_if.led4     = r_led[3];
  assign led_if.led_done = r_done;

endmodule

// File: tb/tb_gpio_led_module.sv
// Directed bench for gpio_led_module (default build) at TICK_CYCLES = 16, 2 and 5.
module tb_gpio_led_module;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  gpio_led_module_if if16();
  gpio_led_module_if if2();
  gpio_led_module_if if5();

  gpio_led_module #(.TICK_CYCLES(16)) dut16 (.clk(clk), .rst(rst), .led_if(if16));
  gpio_led_module #(.TICK_CYCLES(2))  dut2  (.clk(clk), .rst(rst), .led_if(if2));
  gpio_led_module #(.TICK_CYCLES(5))  dut5  (.clk(clk), .rst(rst), .led_if(if5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {led1,led2,led3,led4,led_done} after edge k since release.
  function automatic logic [4:0] exp_leds(input int k, input int t);
    return {k >= t, k >= 2*t, k >= 3*t, k >= 4*t, k >= 5*t};
  endfunction

  task automatic chk(input string tag, input int k, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic chk_all(input int k);
    chk("t16", k, {if16.led1, if16.led2, if16.led3, if16.led4, if16.led_done}, exp_leds(k, 16));
    chk("t2",  k, {if2.led1,  if2.led2,  if2.led3,  if2.led4,  if2.led_done},  exp_leds(k, 2));
    chk("t5",  k, {if5.led1,  if5.led2,  if5.led3,  if5.led4,  if5.led_done},  exp_leds(k, 5));
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;

    // Reset hold: everything stays 0 on every cycle.
    for (int i = 0; i < 10; i++) begin
      edge_wait();
      chk_all(0);
    end

    // Default sequence, boundaries checked edge by edge.
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      edge_wait();
      chk_all(k);
    end
    chk("t16_edge100", 100, {if16.led1, if16.led2, if16.led3, if16.led4, if16.led_done}, 5'b11111);

    // Single-cycle reset from DONE, then run to edge 40.
    @(negedge clk) rst = 1'b1;
    edge_wait();
    chk_all(0);
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      edge_wait();
      chk_all(k);
    end
    chk("t16_edge40", 40, {if16.led1, if16.led2, if16.led3, if16.led4, if16.led_done}, 5'b11000);

    // Mid-sequence reset: outputs clear on the next edge, sequence restarts.
    @(negedge clk) rst = 1'b1;
    edge_wait();
    chk_all(0);
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 10000; k++) begin
      edge_wait();
      chk_all(k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
